// File: rtl/keycode_pkg.sv
// Shared types and keycode constants for the keycode direction controller.
package keycode_pkg;

  // Direction request encoding seen by the movement logic.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Key class after decoding the raw HID keycode.
  typedef enum logic [2:0] {
    KC_NONE  = 3'd0,
    KC_UP    = 3'd1,
    KC_DOWN  = 3'd2,
    KC_LEFT  = 3'd3,
    KC_RIGHT = 3'd4,
    KC_PAUSE = 3'd5
  } kclass_t;

  // USB HID usage codes: WASD plus the arrow keys, and space.
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_UPAR  = 8'h52;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_DNAR  = 8'h51;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_LFAR  = 8'h50;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_RTAR  = 8'h4F;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  // True for the four classes that produce a direction request.
  function automatic logic is_dir_class(input kclass_t c);
    return (c == KC_UP) || (c == KC_DOWN) || (c == KC_LEFT) || (c == KC_RIGHT);
  endfunction

  // Map a direction class onto the request encoding.
  function automatic dir_t class_to_dir(input kclass_t c);
    dir_t d;
    case (c)
      KC_DOWN:  d = DIR_DOWN;
      KC_LEFT:  d = DIR_LEFT;
      KC_RIGHT: d = DIR_RIGHT;
      default:  d = DIR_UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keycode_classify.sv
// Combinational decode of a raw HID keycode into a key class.
module keycode_classify
  import keycode_pkg::*;
(
  input  logic [7:0] i_keycode,
  output kclass_t    o_class
);

  // Every unlisted code, including 0x00 (no key), decodes to NONE.
  always_comb begin
    o_class = KC_NONE;
    case (i_keycode)
      KEY_W,    KEY_UPAR: o_class = KC_UP;
      KEY_S,    KEY_DNAR: o_class = KC_DOWN;
      KEY_A,    KEY_LFAR: o_class = KC_LEFT;
      KEY_D,    KEY_RTAR: o_class = KC_RIGHT;
      KEY_SPACE:          o_class = KC_PAUSE;
      default:            o_class = KC_NONE;
    endcase
  end

endmodule

// File: rtl/keycode_dir_ctrl.sv
// Frame-rate debounce of the keycode PIO into one-shot direction requests
// (valid/ready, single latest-wins entry) and a space-bar pause toggle.
module keycode_dir_ctrl
  import keycode_pkg::*;
#(
  parameter int STABLE_TICKS = 2,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  output logic       dir_valid,
  output logic [1:0] dir,
  input  logic       dir_ready,
  output logic       pause,
  output logic       key_active
);

  localparam logic [CNT_W-1:0] LP_STABLE = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

  kclass_t          w_class;
  kclass_t          r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fired;
  logic             r_pause;
  logic             r_dir_valid;
  dir_t             r_dir;

  logic             w_same;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_fired_base;
  logic             w_accept;
  logic             w_load;
  logic             w_toggle;

  keycode_classify u_classify (
    .i_keycode (keycode),
    .o_class   (w_class)
  );

  // Next-count and accept decision for the current frame_tick; the new
  // candidate is always the sampled class, so only cnt/fired need care.
  always_comb begin
    w_same       = (w_class == r_cand);
    w_cnt_next   = LP_ONE;
    w_fired_base = 1'b0;
    if (w_same) begin
      w_cnt_next   = (r_cnt >= LP_STABLE) ? LP_STABLE : r_cnt + LP_ONE;
      w_fired_base = r_fired;
    end
    w_accept = frame_tick && (w_cnt_next == LP_STABLE) && !w_fired_base &&
               (w_class != KC_NONE);
    w_load   = w_accept && is_dir_class(w_class);
    w_toggle = w_accept && (w_class == KC_PAUSE);
  end

  // Stability tracker: candidate class, saturating count and fired flag,
  // updated only on frame ticks so glitches between frames are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand  <= KC_NONE;
      r_cnt   <= '0;
      r_fired <= 1'b0;
    end else if (frame_tick) begin
      r_cand  <= w_class;
      r_cnt   <= w_cnt_next;
      r_fired <= w_fired_base | w_accept;
    end
  end

  // Pause flag flips once per accepted space press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pause <= 1'b0;
    end else if (w_toggle) begin
      r_pause <= ~r_pause;
    end
  end

  // Single-entry request register: a new load beats both a pending value
  // and a same-cycle transfer, so the newest direction is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir_valid <= 1'b0;
      r_dir       <= DIR_UP;
    end else if (w_load) begin
      r_dir_valid <= 1'b1;
      r_dir       <= class_to_dir(w_class);
    end else if (r_dir_valid && dir_ready) begin
      r_dir_valid <= 1'b0;
    end
  end

  assign dir_valid  = r_dir_valid;
  assign dir        = r_dir;
  assign pause      = r_pause;
  assign key_active = r_fired && (r_cand != KC_NONE);

endmodule

// File: doc/keycode_dir_ctrl.md
# keycode_dir_ctrl

- Sits directly downstream of the NIOS-written 8-bit keycode PIO and upstream of the Pac-Man movement logic.
- Samples the raw USB HID keycode once per video frame and filters it: a key must stay stable for a set number of frames before it counts.
- Each accepted direction keypress becomes exactly one direction request, delivered over a valid/ready handshake.
- The space key toggles a pause flag once per press.

## Interface
Parameters:
- STABLE_TICKS, 2, consecutive frame_tick samples of an unchanged key class needed to accept a key; legal range 1..15.
- CNT_W, 4, width of the stability counter; must hold STABLE_TICKS.

Ports:
- clk  in  1  system clock (50 MHz); the block uses this single clock.
- reset  in  1  synchronous, active-high reset.
- keycode  in  8  raw keycode from the PIO out_port; may change on any cycle.
- frame_tick  in  1  one-cycle pulse per frame (vsync-derived); the only sampling instant.
- dir_valid  out  1  a direction request is pending.
- dir  out  2  requested direction: UP=0, DOWN=1, LEFT=2, RIGHT=3.
- dir_ready  in  1  consumer accepts the request.
- pause  out  1  pause flag; toggles once per accepted space press.
- key_active  out  1  an accepted, non-NONE key is still held.

## Operation
- Classify keycode (combinational) into NONE, UP, DOWN, LEFT, RIGHT or PAUSE:
  - UP: 0x1A (W), 0x52.
  - DOWN: 0x16 (S), 0x51.
  - LEFT: 0x04 (A), 0x50.
  - RIGHT: 0x07 (D), 0x4F.
  - PAUSE: 0x2C.
  - NONE: every other code, including 0x00.
- Registers: cand (class), cnt (CNT_W bits), fired (1 bit).
- On every frame_tick:
  - If class == cand: cnt = min(cnt+1, STABLE_TICKS).
  - Otherwise: cand = class, cnt = 1, fired = 0.
- Accept event: on a frame_tick where the new cnt equals STABLE_TICKS, fired == 0, and cand != NONE. The event then sets fired = 1.
  - Accepted direction class: load the output register with dir = class and dir_valid = 1.
  - Accepted PAUSE: toggle pause. No request is generated.
- A held key never fires twice. Re-firing requires a class change (release to NONE, or a different key) followed by a new stable run.
- key_active = fired && cand != NONE.
- Output register, single entry, latest-wins:
  - A new load overwrites a pending, unconsumed request; the older value is dropped.
  - Transfer occurs on a cycle with dir_valid && dir_ready. dir_valid clears the next cycle unless a load occurs in the same cycle, in which case the load wins and dir_valid stays 1 with the new dir.
  - dir is stable while dir_valid && !dir_ready, except when an accept event overwrites it.
- Cycles without frame_tick: cand, cnt and fired hold; keycode glitches between ticks are invisible.

## Timing
- Reset values: dir_valid=0, dir=0 (UP), pause=0, key_active=0, cand=NONE, cnt=0, fired=0. Reset applied mid-operation discards any pending request and clears pause.
- Latency: dir_valid and key_active rise on the cycle after the frame_tick that causes acceptance. With STABLE_TICKS=2, that is the cycle after the second tick that sees the key.
- STABLE_TICKS=1: accept on the first tick that sees a new non-NONE class.
- cnt saturates at STABLE_TICKS; it never wraps.
- dir_ready is ignored while dir_valid=0. dir_valid does not depend combinationally on dir_ready.
- Key change from LEFT straight to RIGHT: counting restarts at 1; RIGHT is accepted STABLE_TICKS ticks later.

## Structure
- Package keycode_pkg holds:
  - the dir_t enum (UP, DOWN, LEFT, RIGHT, 2 bits);
  - the key-class enum (3 bits);
  - localparam keycode constants for all eight direction codes and the space code.
- Sub-module keycode_classify: purely combinational, keycode[7:0] in, class out.
- Top level holds the stability counter, fired flag, pause toggle and output register.

## Test plan
- Reset, then keycode=0x1A held across 2 ticks -> dir_valid=1, dir=0 one cycle after tick 2; dir_ready=1 for one cycle -> dir_valid=0; further ticks with the same key -> no new request.
- keycode=0x50 held with dir_ready=0, then changed to 0x4F and held 2 ticks -> dir changes from 2 to 3 while dir_valid stays 1 (overwrite).
- keycode toggles 0x07/0x00 every tick -> no request ever; key_active stays 0.
- 0x2C held 5 ticks, released for 1 tick, then held again for 2 ticks -> pause 0→1 after the first press and 1→0 after the second; dir_valid stays 0 throughout.
- Acceptance tick coincides with dir_valid && dir_ready on an older request -> dir_valid stays 1 and shows the new dir.
- Reset asserted while dir_valid=1 and pause=1 -> next cycle all outputs 0; the same held key needs STABLE_TICKS new ticks to fire.
